// File: rtl/fetch_pkg.sv
// Shared types and AXI constants for the instruction fetch burst queue.
// No logic; latency and backpressure are defined by the modules that import it.
package fetch_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ADDR  = 3'd1,
    DATA  = 3'd2,
    DRAIN = 3'd3,
    HALT  = 3'd4
  } fetch_state_t;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [1:0] AXI_BURST_WRAP = 2'b10;

  function automatic logic [2:0] axi_size(input int data_w);
    return 3'($clog2(data_w / 8));
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Circular instruction queue; a push is visible at the head one cycle later.
// No internal backpressure: the owner never pushes when full; flush wins over push/pop.
module fetch_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  input  logic                     flush,
  output logic [WIDTH-1:0]         pop_data,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;

  always_ff @(posedge clk) begin
    if (!reset_n || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  // Storage needs no reset; stale words are never visible while count is 0.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  assign pop_data = mem[rd_ptr];

endmodule

// File: rtl/fetch_burst_queue.sv
// Fetches fixed-length AXI INCR bursts into an instruction queue for decode; word visible 1 cycle after its beat.
// Decode stalls via out_ready; a new burst is requested only when a whole burst fits in the queue.
module fetch_burst_queue
  import fetch_pkg::*;
#(
  parameter int ADDR_W    = 64,
  parameter int DATA_W    = 64,
  parameter int BURST_LEN = 8,
  parameter int DEPTH     = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] entry,
  output logic [ADDR_W-1:0] m_axi_araddr,
  output logic              m_axi_arvalid,
  input  logic              m_axi_arready,
  output logic [7:0]        m_axi_arlen,
  output logic [2:0]        m_axi_arsize,
  output logic [1:0]        m_axi_arburst,
  input  logic [DATA_W-1:0] m_axi_rdata,
  input  logic              m_axi_rvalid,
  input  logic              m_axi_rlast,
  output logic              m_axi_rready,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_instr,
  output logic [ADDR_W-1:0] out_addr,
  output logic              halted
);

  localparam int BYTES = DATA_W / 8;
  localparam int CW    = $clog2(DEPTH) + 1;
  localparam logic [ADDR_W-1:0] BEAT_INC   = ADDR_W'(BYTES);
  localparam logic [ADDR_W-1:0] BURST_INC  = ADDR_W'(BURST_LEN * BYTES);
  localparam logic [ADDR_W-1:0] ALIGN_MASK = ~(ADDR_W'(BYTES - 1));
  localparam logic [CW-1:0]     DEPTH_C    = CW'(DEPTH);
  localparam logic [CW-1:0]     BURST_C    = CW'(BURST_LEN);

  fetch_state_t state;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] beat_addr;
  logic [ADDR_W-1:0] pend_pc;
  logic              pend_redir;
  logic              halt_after_drain;
  logic [CW-1:0]     count;
  logic              push;
  logic              pop;
  logic              flush;
  logic              beat;
  logic              ar_fire;
  logic              zero_word;
  logic [ADDR_W-1:0] redir_aligned;
  logic [ADDR_W+DATA_W-1:0] pop_data;

  assign beat          = m_axi_rvalid && m_axi_rready;
  assign ar_fire       = m_axi_arvalid && m_axi_arready;
  assign zero_word     = (m_axi_rdata == '0);
  assign redir_aligned = redirect_pc & ALIGN_MASK;

  always_comb begin
    push  = 1'b0;
    flush = 1'b0;
    case (state)
      IDLE:  flush = redirect_valid;
      ADDR:  flush = ar_fire && (pend_redir || redirect_valid);
      DATA: begin
        flush = redirect_valid;
        push  = beat && !zero_word && !redirect_valid;
      end
      DRAIN: flush = redirect_valid && !halt_after_drain;
      default: ;
    endcase
  end

  assign pop = out_valid && out_ready;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state            <= IDLE;
      pc               <= entry & ALIGN_MASK;
      m_axi_araddr     <= '0;
      beat_addr        <= '0;
      pend_pc          <= '0;
      pend_redir       <= 1'b0;
      halt_after_drain <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (redirect_valid) begin
            pc <= redir_aligned;
          end else if (DEPTH_C - count >= BURST_C) begin
            state        <= ADDR;
            m_axi_araddr <= pc;
          end
        end
        ADDR: begin
          // The AR request must stay stable, so a redirect here only takes effect after the handshake.
          if (redirect_valid) begin
            pend_redir <= 1'b1;
            pend_pc    <= redir_aligned;
          end
          if (ar_fire) begin
            beat_addr  <= m_axi_araddr;
            pend_redir <= 1'b0;
            if (redirect_valid) begin
              pc    <= redir_aligned;
              state <= DRAIN;
            end else if (pend_redir) begin
              pc    <= pend_pc;
              state <= DRAIN;
            end else begin
              state <= DATA;
            end
          end
        end
        DATA: begin
          if (beat) beat_addr <= beat_addr + BEAT_INC;
          if (redirect_valid) begin
            pc    <= redir_aligned;
            state <= (beat && m_axi_rlast) ? IDLE : DRAIN;
          end else if (beat) begin
            if (zero_word) begin
              if (m_axi_rlast) begin
                state <= HALT;
              end else begin
                state            <= DRAIN;
                halt_after_drain <= 1'b1;
              end
            end else if (m_axi_rlast) begin
              state <= IDLE;
              pc    <= pc + BURST_INC;
            end
          end
        end
        DRAIN: begin
          if (redirect_valid && !halt_after_drain) pc <= redir_aligned;
          if (beat && m_axi_rlast) begin
            state            <= halt_after_drain ? HALT : IDLE;
            halt_after_drain <= 1'b0;
          end
        end
        HALT: ;
        default: state <= IDLE;
      endcase
    end
  end

  fetch_fifo #(
    .WIDTH (ADDR_W + DATA_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (push),
    .push_data ({beat_addr, m_axi_rdata}),
    .pop       (pop),
    .flush     (flush),
    .pop_data  (pop_data),
    .count     (count)
  );

  assign m_axi_arvalid = (state == ADDR);
  assign m_axi_rready  = (state == DATA) || (state == DRAIN);
  assign halted        = (state == HALT);
  assign m_axi_arlen   = 8'(BURST_LEN - 1);
  assign m_axi_arsize  = axi_size(DATA_W);
  assign m_axi_arburst = AXI_BURST_INCR;
  assign out_valid     = (count != '0);
  assign out_addr      = pop_data[ADDR_W+DATA_W-1:DATA_W];
  assign out_instr     = pop_data[DATA_W-1:0];

endmodule

// File: tb/tb_fetch_burst_queue.sv
// Directed bench for fetch_burst_queue: an AXI read-slave model issues beats and queues the
// expected decode words; an independent monitor pops and compares on every out_valid&out_ready.
module tb_fetch_burst_queue;

  localparam int ADDR_W = 64;
  localparam int DATA_W = 64;

  logic              clk = 1'b0;
  logic              reset_n;
  logic [ADDR_W-1:0] entry;
  logic [ADDR_W-1:0] m_axi_araddr;
  logic              m_axi_arvalid;
  logic              m_axi_arready;
  logic [7:0]        m_axi_arlen;
  logic [2:0]        m_axi_arsize;
  logic [1:0]        m_axi_arburst;
  logic [DATA_W-1:0] m_axi_rdata;
  logic              m_axi_rvalid;
  logic              m_axi_rlast;
  logic              m_axi_rready;
  logic              redirect_valid;
  logic [ADDR_W-1:0] redirect_pc;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_instr;
  logic [ADDR_W-1:0] out_addr;
  logic              halted;

  int n_checks = 0;
  int n_fail   = 0;
  logic [127:0] exp_q [$];
  logic [127:0] mon_e;

  always #5 clk = ~clk;

  fetch_burst_queue #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .BURST_LEN(8), .DEPTH(16)
  ) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .entry          (entry),
    .m_axi_araddr   (m_axi_araddr),
    .m_axi_arvalid  (m_axi_arvalid),
    .m_axi_arready  (m_axi_arready),
    .m_axi_arlen    (m_axi_arlen),
    .m_axi_arsize   (m_axi_arsize),
    .m_axi_arburst  (m_axi_arburst),
    .m_axi_rdata    (m_axi_rdata),
    .m_axi_rvalid   (m_axi_rvalid),
    .m_axi_rlast    (m_axi_rlast),
    .m_axi_rready   (m_axi_rready),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_instr      (out_instr),
    .out_addr       (out_addr),
    .halted         (halted)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] beat_data(input logic [63:0] a);
    return {a[31:0] ^ 32'h5A5A_5A5A, 32'hC0DE_0001};
  endfunction

  always @(negedge clk) begin
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_output: got addr 0x%0h, required no output", out_addr);
      end else begin
        mon_e = exp_q.pop_front();
        check("out_addr", out_addr, mon_e[127:64]);
        check("out_instr", out_instr, mon_e[63:0]);
      end
    end
  end

  task automatic apply_reset(input logic [63:0] e, input int cyc);
    entry   = e;
    reset_n = 1'b0;
    repeat (cyc) @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  // Waits for the AR request, checks it, optionally pulses a redirect while it is held, then accepts it.
  task automatic do_ar(input logic [63:0] exp_addr, input bit hold_redir, input logic [63:0] rpc);
    bit found = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (m_axi_arvalid) begin
        found = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    if (!found) begin
      n_checks++;
      n_fail++;
      $display("FAIL ar_timeout: got no arvalid, required araddr 0x%0h", exp_addr);
      return;
    end
    check("araddr", m_axi_araddr, exp_addr);
    check("arlen", 64'(m_axi_arlen), 64'd7);
    check("arsize", 64'(m_axi_arsize), 64'd3);
    check("arburst", 64'(m_axi_arburst), 64'd1);
    if (hold_redir) begin
      redirect_valid = 1'b1;
      redirect_pc    = rpc;
      @(posedge clk); #1;
      redirect_valid = 1'b0;
      repeat (2) begin @(posedge clk); #1; end
      check("arvalid_held", 64'(m_axi_arvalid), 64'd1);
      check("araddr_held", m_axi_araddr, exp_addr);
    end
    m_axi_arready = 1'b1;
    @(posedge clk); #1;
    m_axi_arready = 1'b0;
  endtask

  // Drives nbeats beats; the first `keep` of them are expected to reach decode.
  task automatic send_burst(input logic [63:0] base, input int nbeats, input int keep,
                            input int zero_idx, input int redir_idx, input logic [63:0] rpc);
    logic [63:0] a, d;
    for (int k = 0; k < nbeats; k++) begin
      a = base + 64'(k * 8);
      d = (k == zero_idx) ? 64'd0 : beat_data(a);
      m_axi_rvalid = 1'b1;
      m_axi_rdata  = d;
      m_axi_rlast  = (k == 7);
      if (k == redir_idx) begin
        redirect_valid = 1'b1;
        redirect_pc    = rpc;
      end
      if (k < keep) exp_q.push_back({a, d});
      check("rready", 64'(m_axi_rready), 64'd1);
      @(posedge clk); #1;
      redirect_valid = 1'b0;
    end
    m_axi_rvalid = 1'b0;
    m_axi_rlast  = 1'b0;
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 200; i++) begin
      if (exp_q.size() == 0) return;
      @(posedge clk); #1;
    end
    n_checks++;
    n_fail++;
    $display("FAIL drain_timeout: got %0d words pending, required 0", exp_q.size());
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got simulation still running, required completion");
    n_fail++;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $fatal(1);
  end

  initial begin
    bit saw_ar;
    reset_n = 1'b0;
    entry = 64'h1004;
    m_axi_arready = 1'b0;
    m_axi_rdata = '0;
    m_axi_rvalid = 1'b0;
    m_axi_rlast = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = '0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_arvalid", 64'(m_axi_arvalid), 64'd0);
    check("rst_rready", 64'(m_axi_rready), 64'd0);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_halted", 64'(halted), 64'd0);
    check("rst_araddr", m_axi_araddr, 64'd0);
    reset_n = 1'b1;
    out_ready = 1'b1;

    // Streaming with decode always ready; entry 0x1004 aligns to 0x1000.
    do_ar(64'h1000, 1'b0, 64'd0);
    send_burst(64'h1000, 8, 8, -1, -1, 64'd0);
    wait_drain();

    // Decode stalled: two bursts fill the queue, the third waits for 8 free slots.
    out_ready = 1'b0;
    do_ar(64'h1040, 1'b0, 64'd0);
    send_burst(64'h1040, 8, 8, -1, -1, 64'd0);
    do_ar(64'h1080, 1'b0, 64'd0);
    send_burst(64'h1080, 8, 8, -1, -1, 64'd0);
    saw_ar = 1'b0;
    repeat (10) begin @(posedge clk); #1; saw_ar |= m_axi_arvalid; end
    check("no_ar_when_full", 64'(saw_ar), 64'd0);
    check("out_valid_full", 64'(out_valid), 64'd1);
    out_ready = 1'b1;
    repeat (7) begin @(posedge clk); #1; end
    out_ready = 1'b0;
    saw_ar = 1'b0;
    repeat (5) begin @(posedge clk); #1; saw_ar |= m_axi_arvalid; end
    check("no_ar_7_popped", 64'(saw_ar), 64'd0);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    do_ar(64'h10C0, 1'b0, 64'd0);
    out_ready = 1'b1;
    send_burst(64'h10C0, 8, 8, -1, -1, 64'd0);
    wait_drain();

    // Redirect at beat 3 flushes queued beats and drains the rest.
    out_ready = 1'b0;
    do_ar(64'h1100, 1'b0, 64'd0);
    send_burst(64'h1100, 8, 0, -1, 3, 64'h2004);
    check("queue_empty_redirect", 64'(out_valid), 64'd0);
    do_ar(64'h2000, 1'b0, 64'd0);
    out_ready = 1'b1;
    send_burst(64'h2000, 8, 8, -1, -1, 64'd0);

    // Redirect while AR is held: request stays stable, its burst is discarded.
    do_ar(64'h2040, 1'b1, 64'h3000);
    send_burst(64'h2040, 8, 0, -1, -1, 64'd0);
    do_ar(64'h3000, 1'b0, 64'd0);
    send_burst(64'h3000, 8, 8, -1, -1, 64'd0);

    // Zero word at beat 5 halts the fetcher; redirects are ignored afterwards.
    do_ar(64'h3040, 1'b0, 64'd0);
    send_burst(64'h3040, 8, 5, 5, -1, 64'd0);
    check("halted", 64'(halted), 64'd1);
    redirect_valid = 1'b1;
    redirect_pc    = 64'h8000;
    @(posedge clk); #1;
    redirect_valid = 1'b0;
    saw_ar = 1'b0;
    repeat (20) begin @(posedge clk); #1; saw_ar |= m_axi_arvalid; end
    check("no_ar_halted", 64'(saw_ar), 64'd0);
    check("still_halted", 64'(halted), 64'd1);
    wait_drain();

    // Reset for one cycle in the middle of a burst.
    apply_reset(64'h4000, 1);
    do_ar(64'h4000, 1'b0, 64'd0);
    send_burst(64'h4000, 3, 3, -1, -1, 64'd0);
    entry        = 64'h5000;
    reset_n      = 1'b0;
    m_axi_rvalid = 1'b1;
    m_axi_rdata  = beat_data(64'h4018);
    @(posedge clk); #1;
    check("mid_rst_arvalid", 64'(m_axi_arvalid), 64'd0);
    check("mid_rst_rready", 64'(m_axi_rready), 64'd0);
    check("mid_rst_out_valid", 64'(out_valid), 64'd0);
    check("mid_rst_halted", 64'(halted), 64'd0);
    check("mid_rst_araddr", m_axi_araddr, 64'd0);
    reset_n = 1'b1;
    check("post_rst_rready", 64'(m_axi_rready), 64'd0);
    @(posedge clk); #1;
    m_axi_rvalid = 1'b0;
    check("post_rst_out_valid", 64'(out_valid), 64'd0);
    do_ar(64'h5000, 1'b0, 64'd0);
    send_burst(64'h5000, 8, 8, -1, -1, 64'd0);

    // PC at the top of the address space wraps to zero.
    apply_reset(64'hFFFF_FFFF_FFFF_FFC0, 2);
    do_ar(64'hFFFF_FFFF_FFFF_FFC0, 1'b0, 64'd0);
    send_burst(64'hFFFF_FFFF_FFFF_FFC0, 8, 8, -1, -1, 64'd0);
    do_ar(64'h0, 1'b0, 64'd0);
    send_burst(64'h0, 8, 8, -1, -1, 64'd0);
    wait_drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
